int_mul_pipe: RTL

//  Parametrised, elastic, pipelined integer multiplier for the EX-stage M-extension unit; next generation of the fixed 32-bit array multiplier.

---
 rtl/int_mul_pkg.sv | 18 +
 rtl/int_mul_csa_slice.sv | 31 +++
 rtl/int_mul_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/int_mul_pkg.sv
// int_mul_pkg: op encoding, row split and operand-sign decode for int_mul_pipe.
package int_mul_pkg;
  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;
  function automatic int rows_per_stage(int xlen, int stages);
    return (xlen + stages - 1) / (stages - 1);
  endfunction
  function automatic logic a_signed(mul_op_t op);
    return op == MUL_OP_MULH || op == MUL_OP_MULHSU;
  endfunction
  function automatic logic b_signed(mul_op_t op);
    return op == MUL_OP_MULH;
  endfunction
endpackage

// File: rtl/int_mul_csa_slice.sv
// int_mul_csa_slice: folds ROWS partial-product rows, starting at ROW_BASE, into a carry-save pair.
module int_mul_csa_slice #(
  parameter int XLEN     = 32,
  parameter int ROWS     = 11,
  parameter int ROW_BASE = 0
) (
  input  logic [2*XLEN+1:0] a_i,
  input  logic [XLEN:0]     b_i,
  input  logic [2*XLEN+1:0] sum_i,
  input  logic [2*XLEN+1:0] carry_i,
  output logic [2*XLEN+1:0] sum_o,
  output logic [2*XLEN+1:0] carry_o
);
  logic [2*XLEN+1:0] row, t;
  int idx;
  // row XLEN carries the negative weight of the extended sign bit of b
  always_comb begin
    sum_o   = sum_i;
    carry_o = carry_i;
    row     = '0;
    t       = '0;
    idx     = 0;
    for (int r = 0; r < ROWS; r++) begin
      idx     = ROW_BASE + r;
      row     = (idx <= XLEN && b_i[idx % (XLEN + 1)]) ? ((idx == XLEN ? -a_i : a_i) << idx) : '0;
      t       = sum_o ^ carry_o ^ row;
      carry_o = ((sum_o & carry_o) | (sum_o & row) | (carry_o & row)) << 1;
      sum_o   = t;
    end
  end
endmodule

// File: rtl/int_mul_pipe.sv
// int_mul_pipe: elastic STAGES-deep RV M-extension multiplier, flops on negedge clk_i.
// Define INT_MUL_TAG_EN to carry tag_i alongside each op to tag_o.
module int_mul_pipe
  import int_mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int P   = 2*XLEN + 2;
  localparam int RPS = rows_per_stage(XLEN, STAGES);
  logic [STAGES-1:0] v_q, v_d, adv, ld;
  logic              rdy_q;
  mul_op_t           op_n;
  mul_op_t           op_in [STAGES-1], op_q [STAGES-1], op_d [STAGES-1];
  logic [P-1:0]      a_in [STAGES-1], a_q [STAGES-1], a_d [STAGES-1];
  logic [XLEN:0]     b_in [STAGES-1], b_q [STAGES-1], b_d [STAGES-1];
  logic [P-1:0]      s_in [STAGES-1], s_q [STAGES-1], s_d [STAGES-1], ss [STAGES-1];
  logic [P-1:0]      c_in [STAGES-1], c_q [STAGES-1], c_d [STAGES-1], cc [STAGES-1];
  logic [P-1:0]      prod;
  logic [XLEN-1:0]   result_q, result_d;
  logic              unused_hi;
  // ready chain runs combinationally back from out_ready_i so a full pipe streams without bubbles
  always_comb begin
    adv[STAGES-1] = v_q[STAGES-1] & out_ready_i;
    for (int k = STAGES-2; k >= 0; k--) adv[k] = v_q[k] & (!v_q[k+1] | adv[k+1]);
    in_ready_o = rdy_q & !flush_i & (!v_q[0] | adv[0]);
    ld = {adv[STAGES-2:0], in_valid_i & in_ready_o};
    for (int k = 0; k < STAGES; k++) v_d[k] = !flush_i & (ld[k] | (v_q[k] & !adv[k]));
  end
  always_comb begin
    op_n     = mul_op_t'(op_i);
    op_in[0] = op_n;
    a_in[0]  = {{(P-XLEN){a_signed(op_n) & a_i[XLEN-1]}}, a_i};
    b_in[0]  = {b_signed(op_n) & b_i[XLEN-1], b_i};
    s_in[0]  = '0;
    c_in[0]  = '0;
    for (int k = 1; k < STAGES-1; k++) begin
      op_in[k] = op_q[k-1];
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      s_in[k]  = s_q[k-1];
      c_in[k]  = c_q[k-1];
    end
  end
  for (genvar k = 0; k < STAGES-1; k++) begin : g_slice
    int_mul_csa_slice #(.XLEN(XLEN), .ROWS(RPS), .ROW_BASE(k*RPS)) u_slice (
      .a_i(a_in[k]), .b_i(b_in[k]), .sum_i(s_in[k]), .carry_i(c_in[k]),
      .sum_o(ss[k]), .carry_o(cc[k])
    );
  end
  always_comb begin
    for (int k = 0; k < STAGES-1; k++) begin
      op_d[k] = ld[k] ? op_in[k] : op_q[k];
      a_d[k]  = ld[k] ? a_in[k] : a_q[k];
      b_d[k]  = ld[k] ? b_in[k] : b_q[k];
      s_d[k]  = ld[k] ? ss[k] : s_q[k];
      c_d[k]  = ld[k] ? cc[k] : c_q[k];
    end
    prod     = s_q[STAGES-2] + c_q[STAGES-2];
    result_d = ld[STAGES-1] ? (op_q[STAGES-2] == MUL_OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) : result_q;
  end
  assign unused_hi = ^{prod[P-1:2*XLEN], a_q[STAGES-2], b_q[STAGES-2]};
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q      <= '0;
      rdy_q    <= 1'b0;
      result_q <= '0;
      op_q     <= '{default: MUL_OP_MUL};
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      s_q      <= '{default: '0};
      c_q      <= '{default: '0};
    end else begin
      v_q      <= v_d;
      rdy_q    <= 1'b1;
      result_q <= result_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      c_q      <= c_d;
    end
  end
  assign out_valid_o = v_q[STAGES-1];
  assign result_o    = result_q;
`ifdef INT_MUL_TAG_EN
  logic [TAG_W-1:0] tag_q [STAGES], tag_d [STAGES];
  always_comb begin
    tag_d[0] = ld[0] ? tag_i : tag_q[0];
    for (int k = 1; k < STAGES; k++) tag_d[k] = ld[k] ? tag_q[k-1] : tag_q[k];
  end
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tag_q <= '{default: '0};
    else tag_q <= tag_d;
  end
  assign tag_o = tag_q[STAGES-1];
`else
  logic unused_tag;
  assign unused_tag = ^tag_i;
  assign tag_o      = '0;
`endif
endmodule
